vec_fp_reduce: RTL and testbench



---
 rtl/vm_fp_pkg.sv | 23 ++
 rtl/vec_fp_reduce_adder.sv | 41 ++++
 rtl/vec_fp_reduce.sv | 105 ++++++++++
 tb/tb_vec_fp_reduce.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_fp_pkg.sv
// Vector Machine FP word format, shared constants and reduce FSM states.
// Word: sign [23] (forced 0 in results), mantissa [22:8], exponent [7:0].
package vm_fp_pkg;

    localparam int WORD_SIZE = 24;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 15;

    localparam int SIGN_BIT  = 23;
    localparam int MANT_MSB  = 22;
    localparam int MANT_LSB  = 8;

    localparam logic [WORD_SIZE-1:0] ZERO    = 24'h000000;
    localparam logic [WORD_SIZE-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [EXP_W-1:0]     EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/vec_fp_reduce_adder.sv
// Combinational Vector Machine FP adder (magnitudes only, sign ignored).
// Ports: data_1_i, data_2_i operands; sum_o result (exponent wraps on FF+1).
module vec_fp_reduce_adder
    import vm_fp_pkg::*;
(
    input  logic [WORD_SIZE-1:0] data_1_i,
    input  logic [WORD_SIZE-1:0] data_2_i,
    output logic [WORD_SIZE-1:0] sum_o
);

    logic [EXP_W-1:0]  e1, e2, e_max, e_res;
    logic [MANT_W-1:0] m1, m2, a1, a2, m_res;
    logic [MANT_W:0]   m_sum;

    always_comb begin
        e1 = data_1_i[EXP_W-1:0];
        e2 = data_2_i[EXP_W-1:0];
        m1 = data_1_i[MANT_MSB:MANT_LSB];
        m2 = data_2_i[MANT_MSB:MANT_LSB];
        // Equal exponents fall to the second branch (shift by 0).
        if (e1 > e2) begin
            e_max = e1;
            a1    = m1;
            a2    = m2 >> (e1 - e2);
        end else begin
            e_max = e2;
            a1    = m1 >> (e2 - e1);
            a2    = m2;
        end
        m_sum = {1'b0, a1} + {1'b0, a2};
        if (m_sum[MANT_W]) begin
            m_res = m_sum[MANT_W:1];
            e_res = e_max + 8'd1;
        end else begin
            m_res = m_sum[MANT_W-1:0];
            e_res = e_max;
        end
        sum_o = {1'b0, m_res, e_res};
    end

endmodule

// File: rtl/vec_fp_reduce.sv
// Streams one vector through the FP adder, accumulating a scalar sum.
// Ports: clk, rst (async high); start/len launch; in_valid/in_data/in_ready
// element stream; out_valid/out_data/out_ready result; busy = not IDLE.
// VEC_FP_REDUCE_SAT_EN: adds sticky ovf, saturating acc at 24'h7FFFFF.
module vec_fp_reduce #(
    parameter int WORD_SIZE = 24,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy
`ifdef VEC_FP_REDUCE_SAT_EN
    ,
    output logic                 ovf
`endif
);

    import vm_fp_pkg::*;

    state_e               state_q;
    logic [WORD_SIZE-1:0] acc_q, acc_d, sum;
    logic [LEN_W-1:0]     cnt_q;
    logic                 hs;

    vec_fp_reduce_adder u_adder (
        .data_1_i (acc_q),
        .data_2_i (in_data),
        .sum_o    (sum)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign hs        = in_valid & in_ready;

`ifdef VEC_FP_REDUCE_SAT_EN
    logic ovf_q, sat_step;

    // Max input exponent FF and result exponent 00 means the carry wrapped.
    always_comb begin
        sat_step = ((acc_q[EXP_W-1:0] == EXP_MAX) ||
                    (in_data[EXP_W-1:0] == EXP_MAX)) &&
                   (sum[EXP_W-1:0] == '0);
        acc_d    = (ovf_q || sat_step) ? SAT_MAX : sum;
    end

    assign ovf = ovf_q;
`else
    assign acc_d = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= ZERO;
            cnt_q   <= '0;
`ifdef VEC_FP_REDUCE_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q <= ZERO;
`ifdef VEC_FP_REDUCE_SAT_EN
                        ovf_q <= 1'b0;
`endif
                        if (len != '0) begin
                            cnt_q   <= len;
                            state_q <= ACCUM;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (hs) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - LEN_W'(1);
`ifdef VEC_FP_REDUCE_SAT_EN
                        ovf_q <= ovf_q | sat_step;
`endif
                        if (cnt_q == LEN_W'(1))
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_fp_reduce.sv
// Randomized self-checking bench for vec_fp_reduce.
// Reference: arithmetic-level FP add model over a queue of elements.
module tb_vec_fp_reduce;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready;
    logic        out_valid, out_ready, busy;
    logic [7:0]  len;
    logic [23:0] in_data, out_data;
`ifdef VEC_FP_REDUCE_SAT_EN
    logic        ovf;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [23:0] q[$];

    always #5 clk = ~clk;

    vec_fp_reduce #(.WORD_SIZE(24), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef VEC_FP_REDUCE_SAT_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mdl_add(input logic [23:0] a,
                                            input logic [23:0] b,
                                            output bit wrapped);
        int ea, eb, ma, mb, em, s;
        ea = int'(a[7:0]);
        eb = int'(b[7:0]);
        ma = int'(a[22:8]);
        mb = int'(b[22:8]);
        em = (ea > eb) ? ea : eb;
        s  = (ma >> (em - ea)) + (mb >> (em - eb));
        wrapped = 1'b0;
        if (s >= 32768) begin
            s  = s / 2;
            em = em + 1;
        end
        if (em == 256) begin
            wrapped = 1'b1;
            em      = 0;
        end
        return {1'b0, s[14:0], em[7:0]};
    endfunction

    function automatic logic [23:0] mdl_reduce(output bit ovf_m);
        logic [23:0] acc, r;
        bit w;
        acc   = 24'h0;
        ovf_m = 1'b0;
        foreach (q[k]) begin
            r = mdl_add(acc, q[k], w);
`ifdef VEC_FP_REDUCE_SAT_EN
            if (ovf_m || w) begin
                acc   = 24'h7FFFFF;
                ovf_m = 1'b1;
            end else begin
                acc = r;
            end
`else
            acc = r;
`endif
        end
        return acc;
    endfunction

    // Runs one reduction over q; want < 0 selects the model result.
    task automatic reduce(input string tag, input int want,
                          input int gap_max, input int hold,
                          input bit poke);
        int n, gaps;
        bit eo;
        logic [23:0] exp;
        n   = q.size();
        exp = mdl_reduce(eo);
        if (want >= 0)
            exp = want[23:0];
        start = 1'b1;
        len   = n[7:0];
        step();
        start = 1'b0;
        len   = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            chk({tag, ":rdy"}, {31'd0, in_ready}, 32'd1);
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 24'($urandom);
                step();
                chk({tag, ":gaprdy"}, {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data  = q[i];
            step();
        end
        in_valid = 1'b0;
        chk({tag, ":ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ":od"}, {8'd0, out_data}, {8'd0, exp});
        chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ":rdy0"}, {31'd0, in_ready}, 32'd0);
`ifdef VEC_FP_REDUCE_SAT_EN
        chk({tag, ":ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo) n_chk += 0;
`endif
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (poke) begin
                start = 1'b1;
                len   = 8'($urandom_range(0, 5));
            end
            step();
            start = 1'b0;
            chk({tag, ":hov"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ":hod"}, {8'd0, out_data}, {8'd0, exp});
            chk({tag, ":hbusy"}, {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ":ov0"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":idle"}, {31'd0, busy}, 32'd0);
`ifdef VEC_FP_REDUCE_SAT_EN
        chk({tag, ":ovfk"}, {31'd0, ovf}, {31'd0, eo});
`endif
    endtask

    initial begin
        int n, e;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 24'd0;
        out_ready = 1'b0;
        #12;
        chk("rst:rdy", {31'd0, in_ready}, 32'd0);
        chk("rst:ov", {31'd0, out_valid}, 32'd0);
        chk("rst:od", {8'd0, out_data}, 32'd0);
        chk("rst:busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        q.delete();
        q.push_back(24'h400010);
        q.push_back(24'h400010);
        reduce("b2b", 24'h400011, 0, 0, 1'b0);

        q.delete();
        q.push_back(24'h400010);
        q.push_back(24'h400010);
        q.push_back(24'h400011);
        q.push_back(24'h400010);
        reduce("gaps", 24'h500012, 3, 1, 1'b0);

        q.delete();
        reduce("len0", 24'h000000, 0, 5, 1'b1);

        q.delete();
        q.push_back(24'h4000FF);
        q.push_back(24'h4000FF);
`ifdef VEC_FP_REDUCE_SAT_EN
        reduce("wrap", 24'h7FFFFF, 0, 2, 1'b0);
`else
        reduce("wrap", 24'h400000, 0, 2, 1'b0);
`endif

        // Asynchronous reset in the middle of a reduction.
        start = 1'b1;
        len   = 8'd3;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 24'h400010;
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst:rdy", {31'd0, in_ready}, 32'd0);
        chk("arst:ov", {31'd0, out_valid}, 32'd0);
        chk("arst:od", {8'd0, out_data}, 32'd0);
        chk("arst:busy", {31'd0, busy}, 32'd0);
        #2;
        rst = 1'b0;
        step();
        chk("arst:idle", {31'd0, busy}, 32'd0);
        q.delete();
        q.push_back(24'h123456);
        reduce("post", 24'h123456, 0, 0, 1'b0);

        q.delete();
        q.push_back(24'hC00010);
        q.push_back(24'h400010);
        reduce("sign", 24'h400011, 1, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            q.delete();
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0)
                    e = 240 + $urandom_range(0, 15);
                else
                    e = $urandom_range(0, 255);
                q.push_back({1'($urandom), 15'($urandom), e[7:0]});
            end
            reduce("rand", -1, 2, $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
